// File: rtl/imem_resp_pkg.sv
// Shared defaults for the instruction-memory responder and the built-in program image
// that fills its ROM array.
package imem_resp_pkg;

  localparam int    WORDSIZE   = 32;
  localparam int    IMEM_DEPTH = 256;
  localparam int    IMEM_LAT   = 2;
  localparam string IMEM_INIT  = "imem.hex";

  // Built-in program image: word idx of the instruction array.
  function automatic logic [31:0] imem_word(input logic [31:0] idx);
    return (idx * 32'h0001_0003) ^ 32'h5A5A_0F0F;
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Synchronous FIFO with clear, used as the response buffer of imem_resp.
// When empty, the read port keeps presenting the most recently popped entry.
module resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, hold_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? mem[hold_ptr] : mem[rd_ptr];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      hold_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        hold_ptr <= rd_ptr;
        rd_ptr   <= bump(rd_ptr);
      end
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/imem_resp.sv
// Instruction-memory responder: fixed-latency ROM read pipeline feeding an in-order
// response FIFO, with credit-based request flow control and single-cycle flush.
module imem_resp #(
  parameter int    WORDSIZE  = imem_resp_pkg::WORDSIZE,
  parameter int    DEPTH     = imem_resp_pkg::IMEM_DEPTH,
  parameter int    LAT       = imem_resp_pkg::IMEM_LAT,
  parameter string INIT_FILE = imem_resp_pkg::IMEM_INIT
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WORDSIZE-1:0] req_addr,
  input  logic                flush,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORDSIZE-1:0] rsp_addr,
  output logic [WORDSIZE-1:0] rsp_data,
  output logic                rsp_err
);
  import imem_resp_pkg::*;

  // Handshake: a transfer happens on a channel in every cycle where valid and ready
  // are both high at the rising edge; valid must hold its payload until that cycle.
  localparam int CAP   = LAT + 1;
  localparam int EW    = 2 * WORDSIZE + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(CAP + 1);
  localparam bit BLANK = (INIT_FILE == "");
  localparam logic [WORDSIZE:0] DEPTH_W = (WORDSIZE + 1)'(DEPTH);

  // The image is compiled in from imem_word; an empty INIT_FILE name leaves it zeroed.
  logic [WORDSIZE-1:0] rom [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = BLANK ? '0 : WORDSIZE'(imem_word(32'(i)));
  end

  logic                accept, pop, in_err, out_v;
  logic                fifo_full, fifo_empty;
  logic [WORDSIZE-1:0] in_data;
  logic [EW-1:0]       in_e, out_e, head;
  logic [CW-1:0]       fifo_count, inflight;

  assign pop       = rsp_valid && rsp_ready && !flush;
  assign req_ready = !reset && !flush && ((inflight < CW'(CAP)) || (rsp_valid && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign in_err    = ({1'b0, req_addr} >= DEPTH_W);
  assign in_data   = in_err ? '0 : rom[req_addr[AW-1:0]];
  assign in_e      = {req_addr, in_err, in_data};

  if (LAT == 1) begin : g_direct
    assign out_v = accept;
    assign out_e = in_e;
  end else begin : g_pipe
    logic [LAT-2:0] pv;
    logic [EW-1:0]  pe [LAT-1];

    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        pv <= '0;
        for (int i = 0; i < LAT - 1; i++) pe[i] <= '0;
      end else begin
        pv[0] <= accept;
        pe[0] <= in_e;
        for (int i = 1; i < LAT - 1; i++) begin
          pv[i] <= pv[i-1];
          pe[i] <= pe[i-1];
        end
        if (flush) pv <= '0;
      end
    end

    assign out_v = pv[LAT-2];
    assign out_e = pe[LAT-2];
  end

  // Credits cover pipeline plus FIFO, so a pipeline exit always finds a free slot.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                 inflight <= '0;
    else if (flush)            inflight <= '0;
    else if (accept && !pop)   inflight <= inflight + CW'(1);
    else if (pop && !accept)   inflight <= inflight - CW'(1);
  end

  resp_fifo #(.WIDTH(EW), .DEPTH(CAP)) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .clear (flush),
    .push  (out_v),
    .pop   (pop),
    .wdata (out_e),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign {rsp_addr, rsp_err, rsp_data} = head;

  a_no_overflow: assert property (@(posedge CLK) disable iff (reset)
    !(out_v && fifo_full && !pop && !flush));
  a_credit_covers_fifo: assert property (@(posedge CLK) disable iff (reset)
    fifo_count <= inflight);

endmodule

// File: tb/tb_imem_resp.sv
// Self-checking bench for imem_resp: vector table, directed multi-cycle sequences and
// random traffic against an in-order queue model of the responder.
module tb_imem_resp;

  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int CAP = LAT + 1;

  logic         CLK = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0] req_addr, rsp_addr, rsp_data;

  always #5 CLK = ~CLK;

  imem_resp dut (
    .CLK       (CLK),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic         rv;
    logic [W-1:0] a;
    logic         e_v;
    logic         e_rdy;
    logic [W-1:0] e_a;
    logic         e_err;
  } vec_t;

  vec_t         tbl [15];
  vec_t         cur;
  bit           tbl_on = 1'b0;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [W-1:0] exp_q [$];
  int           due_q [$];
  logic [W-1:0] obs_q [$];
  int           obs_acc = 0;
  logic         exp_valid, exp_ready, last_acc, smp_valid, smp_ready;

  // Expected image: built-in program words inside the array, zero outside it.
  function automatic logic [W-1:0] img(input logic [W-1:0] a);
    return (a < 256) ? ((a * 32'h0001_0003) ^ 32'h5A5A_0F0F) : '0;
  endfunction

  function automatic logic [W-1:0] rand_addr();
    case ($urandom_range(0, 9))
      7:       return W'($urandom_range(256, 1023));
      8:       return 32'hFFFF_FFFF;
      9:       return W'($urandom);
      default: return W'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: sample/check at negedge, advance the model at posedge.
  task automatic step();
    @(negedge CLK);
    exp_valid = (exp_q.size() > 0) && (due_q[0] <= cyc);
    exp_ready = !flush && ((exp_q.size() < CAP) || (exp_valid && rsp_ready));
    smp_valid = rsp_valid;
    smp_ready = req_ready;
    chk("rsp_valid", rsp_valid, exp_valid);
    chk("req_ready", req_ready, exp_ready);
    if (exp_valid) begin
      chk("rsp_addr", rsp_addr, exp_q[0]);
      chk("rsp_data", rsp_data, img(exp_q[0]));
      chk("rsp_err", rsp_err, exp_q[0] >= 256);
    end
    if (tbl_on) begin
      chk("tbl_valid", rsp_valid, cur.e_v);
      chk("tbl_ready", req_ready, cur.e_rdy);
      if (cur.e_v) begin
        chk("tbl_addr", rsp_addr, cur.e_a);
        chk("tbl_err", rsp_err, cur.e_err);
        chk("tbl_data", rsp_data, cur.e_err ? '0 : img(cur.e_a));
      end
    end
    if (rsp_valid === 1'b1 && rsp_ready && !flush) obs_q.push_back(rsp_addr);
    if (req_valid && req_ready === 1'b1) obs_acc++;
    last_acc = req_valid && exp_ready;
    @(posedge CLK);
    if (flush) begin
      exp_q.delete();
      due_q.delete();
    end else begin
      if (exp_valid && rsp_ready) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (req_valid && exp_ready) begin
        exp_q.push_back(req_addr);
        due_q.push_back(cyc + LAT);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b1, 32'd0,          1'b0, 1'b1, 32'd0,          1'b0};
    tbl[1]  = '{1'b1, 32'd1,          1'b0, 1'b1, 32'd0,          1'b0};
    tbl[2]  = '{1'b1, 32'd2,          1'b1, 1'b1, 32'd0,          1'b0};
    tbl[3]  = '{1'b1, 32'd3,          1'b1, 1'b1, 32'd1,          1'b0};
    tbl[4]  = '{1'b0, 32'd0,          1'b1, 1'b1, 32'd2,          1'b0};
    tbl[5]  = '{1'b0, 32'd0,          1'b1, 1'b1, 32'd3,          1'b0};
    tbl[6]  = '{1'b0, 32'd0,          1'b0, 1'b1, 32'd0,          1'b0};
    tbl[7]  = '{1'b1, 32'd300,        1'b0, 1'b1, 32'd0,          1'b0};
    tbl[8]  = '{1'b1, 32'd5,          1'b0, 1'b1, 32'd0,          1'b0};
    tbl[9]  = '{1'b0, 32'd0,          1'b1, 1'b1, 32'd300,        1'b1};
    tbl[10] = '{1'b0, 32'd0,          1'b1, 1'b1, 32'd5,          1'b0};
    tbl[11] = '{1'b1, 32'hFFFF_FFFF,  1'b0, 1'b1, 32'd0,          1'b0};
    tbl[12] = '{1'b0, 32'd0,          1'b0, 1'b1, 32'd0,          1'b0};
    tbl[13] = '{1'b0, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF,  1'b1};
    tbl[14] = '{1'b0, 32'd0,          1'b0, 1'b1, 32'd0,          1'b0};

    // Clock/reset
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge CLK); #2 reset = 1'b0;

    // Streaming and out-of-range vectors
    tbl_on = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cur = tbl[i];
      req_valid = cur.rv; req_addr = cur.a; rsp_ready = 1'b1; flush = 1'b0;
      step();
    end
    tbl_on = 1'b0;

    // Back-pressure: exactly CAP accepts, then everything drains in order
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd40; obs_acc = 0; obs_q.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_acc) req_addr++;
    end
    chk("bp_accepts", obs_acc, CAP);
    chk("bp_ready_low", smp_ready, 0);
    rsp_ready = 1'b1;
    idle(6);
    chk("bp_drain_count", obs_q.size(), CAP);
    for (int i = 0; i < obs_q.size() && i < CAP; i++) chk("bp_drain_order", obs_q[i], 40 + i);

    // Flush with three in flight and a request presented alongside
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      req_addr++;
    end
    flush = 1'b1; req_addr = 32'd9;
    step();
    chk("flush_blocks_req", smp_ready, 0);
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; obs_q.delete();
    step();
    chk("flush_ready_next", smp_ready, 1);
    chk("flush_no_rsp", smp_valid, 0);
    req_valid = 1'b1; req_addr = 32'd20;
    step();
    idle(5);
    chk("flush_rsp_count", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("flush_rsp_addr", obs_q[0], 20);

    // Asynchronous reset between edges with two entries buffered
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd50;
    step();
    req_addr = 32'd51;
    step();
    idle(3);
    chk("mr_buffered", smp_valid, 1);
    #3 reset = 1'b1;
    #1;
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_req_ready", req_ready, 0);
    chk("mr_rsp_addr", rsp_addr, 0);
    chk("mr_rsp_data", rsp_data, 0);
    chk("mr_rsp_err", rsp_err, 0);
    exp_q.delete(); due_q.delete();
    @(posedge CLK); #3 reset = 1'b0;
    obs_q.delete(); rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'd77;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && obs_q.size() == 0; i++) step();
    chk("mr_first_rsp_seen", obs_q.size() > 0, 1);
    if (obs_q.size() > 0) chk("mr_first_rsp_addr", obs_q[0], 77);

    // Full occupancy with simultaneous accept and pop
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd100; obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_acc) req_addr++;
    end
    rsp_ready = 1'b1; obs_acc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_acc) req_addr++;
    end
    chk("full_thru_acc", obs_acc, 10);
    idle(6);
    chk("full_rsp_count", obs_q.size(), 13);
    for (int i = 0; i < obs_q.size() && i < 13; i++) chk("full_rsp_order", obs_q[i], 100 + i);

    // Random traffic against the queue model
    req_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!req_valid || last_acc) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_addr  = rand_addr();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    flush = 1'b0; rsp_ready = 1'b1;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
